// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer. It borrows the shared 32-bit ALU for one add or
// subtract per cycle and leaves the 64-bit result in the HI/LO pair.
module alu_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_x_hi;   // acc_hi (MUL) / partial remainder R (DIV)
  logic [WIDTH-1:0] r_x_lo;   // acc_lo (MUL) / quotient shifter Q (DIV)
  logic [WIDTH-1:0] r_opnd;   // multiplicand (MUL) / divisor D (DIV)
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_dbz;

  logic             w_last;
  logic             w_carry;
  logic             w_ge;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
  assign alu_shamt   = '0;
  assign w_last      = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = ALU_ADD;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op)              w_state_nxt = S_MUL;
          else if (src_b == '0) w_state_nxt = S_DONE;
          else                  w_state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        busy  = 1'b1;
        alu_a = r_x_hi;
        alu_b = r_x_lo[0] ? r_opnd : '0;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DIV: begin
        busy     = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_a    = w_shift;
        alu_b    = r_opnd;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-step datapath. The carry out of the add is recovered by an unsigned wrap compare.
  always_comb begin
    w_shift  = {r_x_hi[WIDTH-2:0], r_x_lo[WIDTH-1]};
    w_carry  = (alu_out < r_x_hi);
    w_ge     = r_x_hi[WIDTH-1] | (w_shift >= r_opnd);
    w_hi_nxt = r_x_hi;
    w_lo_nxt = r_x_lo;
    if (r_state == S_MUL) begin
      {w_hi_nxt, w_lo_nxt} = {w_carry, alu_out, r_x_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      w_hi_nxt = w_ge ? alu_out : w_shift;
      w_lo_nxt = {r_x_lo[WIDTH-2:0], w_ge};
    end
  end

  // NOTE: state is updated with non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_x_hi <= '0;
      r_x_lo <= '0;
      r_opnd <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_dbz <= 1'b0;
            if (!op) begin
              r_x_hi <= '0;
              r_x_lo <= src_b;
              r_opnd <= src_a;
            end else if (src_b != '0) begin
              r_x_hi <= '0;
              r_x_lo <= src_a;
              r_opnd <= src_b;
            end else begin
              r_hi  <= src_a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_x_hi <= w_hi_nxt;
          r_x_lo <= w_lo_nxt;
          if (w_last) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
